wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL expose the parameter DEPTH, default 4, giving the number of entries in the long-latency result queue (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 alu_valid  input  1  single-cycle result present this cycle; fire-and-forget, no ready.
REQ-005 alu_addr  input  5  destination register of the ALU result.
REQ-006 alu_data  input  32  ALU result value.
REQ-007 mdu_valid  input  1  long-latency (mult/div) result offered.
REQ-008 mdu_ready  output  1  queue accepts the offered MDU result.
REQ-009 mdu_addr  input  5  destination register of the MDU result.
REQ-010 mdu_data  input  32  MDU result value.
REQ-011 flush  input  1  synchronous discard of all queued MDU results.
REQ-012 Reg_w  output  1  register-file write enable, registered.
REQ-013 Rd_addr  output  5  register-file write address, registered.
REQ-014 Rd_data  output  32  register-file write data, registered.
REQ-015 pending  output  32  bit i high while a queued, unkilled MDU write to register i exists.

Function
REQ-016 An MDU transfer SHALL occur when mdu_valid and mdu_ready are both high on a rising edge.
REQ-017 mdu_ready SHALL be high when the queue is not full, pending[mdu_addr] is low, and flush is low.
REQ-018 An ALU result SHALL have priority: alu_valid at edge N SHALL give Reg_w=1, Rd_addr=alu_addr, Rd_data=alu_data during cycle N+1.
REQ-019 The queue head SHALL drain to the output registers only in cycles with alu_valid low, one entry per cycle, in FIFO order.
REQ-020 Without bypass, an MDU result accepted at edge N SHALL enter the queue; its earliest write SHALL be Reg_w high in cycle N+2.
REQ-021 Writes to register 0 SHALL be dropped at their source: no Reg_w pulse and no pending bit.
REQ-022 An MDU write to register 0 SHALL still be accepted and consumed by the handshake.
REQ-023 An alu_valid write to register r with pending[r] high SHALL kill the queued entry for r, because the ALU value is newer.
REQ-024 A killed entry SHALL be popped without producing a Reg_w pulse, and its pending bit SHALL clear at the kill edge.
REQ-025 When an entry issues, its pending bit SHALL clear at the same edge as its output-register load.
REQ-026 A push and a pop in the same cycle SHALL leave the occupancy count unchanged.
REQ-027 When the queue is full, mdu_ready SHALL be 0; a pop in that cycle SHALL raise mdu_ready from the next cycle, never combinationally.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 The occupancy counter SHALL be log2(DEPTH)+1 bits wide.
REQ-030 flush SHALL empty the queue, clear all pending bits and suppress any queue issue in that cycle.
REQ-031 flush SHALL NOT block an ALU write in the same cycle.
REQ-032 Reg_w SHALL be 0 in any cycle with neither an ALU write nor a queue write issued.
REQ-033 Rd_addr and Rd_data SHALL hold their last values while Reg_w is 0.

Reset
REQ-034 Asserting rst_n low SHALL immediately force Reg_w=0, Rd_addr=0, Rd_data=0, pending=0, mdu_ready=0, queue empty and pointers 0.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries with no further writes.
REQ-036 mdu_ready SHALL go high in the first cycle after rst_n deasserts.

Configuration
REQ-037 With macro WB_QUEUE_BYPASS_EN defined: if the queue is empty, alu_valid is 0 and flush is 0, an accepted MDU result SHALL load the output registers directly at edge N (Reg_w in cycle N+1) without entering the queue.
REQ-038 With WB_QUEUE_BYPASS_EN undefined: every MDU result SHALL pass through the queue, giving a minimum latency of 2.

Structure
REQ-039 The following SHALL reside in shared package cpu_pkg: register-address width 5, data width 32, zero-register constant, and the queue-entry type {kill, addr, data}.
REQ-040 Queue storage and pointers SHALL be one sub-module, wb_fifo.
REQ-041 The top level SHALL contain arbitration, the kill compare, the pending scoreboard and the output registers.

Verification
REQ-042 Reset, then alu_valid with addr 5, data 0x1234 -> next cycle Reg_w=1, Rd_addr=5, Rd_data=0x1234; pending=0.
REQ-043 Push 4 MDU results (addrs 1-4) while alu_valid is held high -> mdu_ready=0 after the 4th push, pending=0x1E; drop alu_valid -> writes 1,2,3,4 in order on consecutive cycles.
REQ-044 Queue MDU write r7=0xAAAA, then alu_valid r7=0xBBBB before it drains -> exactly one write, r7=0xBBBB; pending[7] clears.
REQ-045 MDU write to register 0 -> handshake completes; no Reg_w pulse; pending stays 0.
REQ-046 Queue 3 entries, assert flush for one cycle -> no subsequent Reg_w; pending=0; mdu_ready=1.
REQ-047 Empty queue, single MDU push r9 -> Reg_w in cycle N+1 with WB_QUEUE_BYPASS_EN, N+2 without; rst_n pulsed mid-drain -> outputs are 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types for the writeback path: register/data widths and the
// result-queue entry layout.
package cpu_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic              kill;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result queue: storage, wrapping pointers and occupancy count,
// with an in-place kill of entries matching a given destination register.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_addr,
  output wb_entry_t         head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Only one live entry per register can exist, so marking every match
      // (stale slots included) is safe; a push overwrites its slot afterwards.
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem_q[i].addr == kill_addr) begin
            mem_d[i].kill = 1'b1;
          end else begin
            mem_d[i].kill = mem_q[i].kill;
          end
        end
      end else begin
        mem_d = mem_q;
      end
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/wb_queue.sv
// Writeback arbiter: ALU results win, queued MDU results drain in FIFO order.
// Define WB_QUEUE_BYPASS_EN to let an MDU result skip the empty queue.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [REG_AW-1:0]   mdu_addr,
  input  logic [DATA_W-1:0]   mdu_data,
  input  logic                flush,
  output logic                Reg_w,
  output logic [REG_AW-1:0]   Rd_addr,
  output logic [DATA_W-1:0]   Rd_data,
  output logic [NUM_REGS-1:0] pending
);

  wb_entry_t head, push_entry;
  logic      full, empty, push, pop, issue, kill, alu_wr, xfer, bypass;

  logic                ready_en_q, ready_en_d;
  logic                reg_w_q, reg_w_d;
  logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (kill),
    .kill_addr  (alu_addr),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // Ready only looks at registered state, so a pop frees space a cycle later.
  always_comb begin
    ready_en_d = 1'b1;
    mdu_ready  = ready_en_q && !full && !pending_q[mdu_addr] && !flush;
    xfer       = mdu_valid && mdu_ready;
    alu_wr     = alu_valid && (alu_addr != ZERO_REG);
    kill       = alu_wr && pending_q[alu_addr];
    pop        = !alu_valid && !empty && !flush;
    issue      = pop && !head.kill;
`ifdef WB_QUEUE_BYPASS_EN
    bypass     = xfer && empty && !alu_valid && !flush;
`else
    bypass     = 1'b0;
`endif
    push       = xfer && (mdu_addr != ZERO_REG) && !bypass;
    push_entry = '{kill: 1'b0, addr: mdu_addr, data: mdu_data};
  end

  always_comb begin
    reg_w_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (alu_wr) begin
      reg_w_d   = 1'b1;
      rd_addr_d = alu_addr;
      rd_data_d = alu_data;
    end else if (issue) begin
      reg_w_d   = 1'b1;
      rd_addr_d = head.addr;
      rd_data_d = head.data;
    end else if (bypass && (mdu_addr != ZERO_REG)) begin
      reg_w_d   = 1'b1;
      rd_addr_d = mdu_addr;
      rd_data_d = mdu_data;
    end else begin
      reg_w_d = 1'b0;
    end
  end

  // Push, kill and issue always name different registers in one cycle.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (push) pending_d[mdu_addr] = 1'b1;
      else      pending_d = pending_d;
      if (kill) pending_d[alu_addr] = 1'b0;
      else      pending_d = pending_d;
      if (issue) pending_d[head.addr] = 1'b0;
      else       pending_d = pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      reg_w_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      pending_q  <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      reg_w_q    <= reg_w_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      pending_q  <= pending_d;
    end
  end

  assign Reg_w   = reg_w_q;
  assign Rd_addr = rd_addr_q;
  assign Rd_data = rd_data_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: a queue-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mdu_valid, flush;
  logic [4:0]  alu_addr, mdu_addr;
  logic [31:0] alu_data, mdu_data;
  logic        mdu_ready, Reg_w;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_data, pending;

  int checks = 0;
  int errors = 0;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .flush     (flush),
    .Reg_w     (Reg_w),
    .Rd_addr   (Rd_addr),
    .Rd_data   (Rd_data),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents as a list of results in arrival order.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          k;
  } ent_t;

  ent_t        mq[$];
  bit          m_w;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          ready_ok;

  function automatic logic [31:0] m_pend();
    logic [31:0] p = 32'd0;
    foreach (mq[i]) if (!mq[i].k && mq[i].a != 5'd0) p[mq[i].a] = 1'b1;
    return p;
  endfunction

  always @(posedge clk) begin
    logic [31:0] pv;
    logic [31:0] exp_rdy;
    bit          acc, byp;
    ent_t        e;
    if (!rst_n) begin
      mq.delete();
      m_w      = 1'b0;
      m_addr   = 5'd0;
      m_data   = 32'd0;
      ready_ok = 1'b0;
    end else begin
      pv  = m_pend();
      acc = ready_ok && mdu_valid && (mq.size() < DEPTH) && !pv[mdu_addr] && !flush;
      byp = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
      byp = acc && (mq.size() == 0) && !alu_valid && !flush;
`endif
      m_w = 1'b0;
      if (alu_valid) begin
        if (alu_addr != 5'd0) begin
          m_w = 1'b1; m_addr = alu_addr; m_data = alu_data;
          foreach (mq[i]) if (mq[i].a == alu_addr) mq[i].k = 1'b1;
        end
      end else if (!flush && mq.size() > 0) begin
        e = mq.pop_front();
        if (!e.k) begin
          m_w = 1'b1; m_addr = e.a; m_data = e.d;
        end
      end else if (byp && mdu_addr != 5'd0) begin
        m_w = 1'b1; m_addr = mdu_addr; m_data = mdu_data;
      end
      if (flush) begin
        mq.delete();
      end else if (acc && !byp && mdu_addr != 5'd0) begin
        e.a = mdu_addr; e.d = mdu_data; e.k = 1'b0;
        mq.push_back(e);
      end
      ready_ok = 1'b1;
    end
    #1;
    pv      = m_pend();
    exp_rdy = {31'd0, rst_n && ready_ok && (mq.size() < DEPTH) && !pv[mdu_addr] && !flush};
    chk("model reg_w",     {31'd0, Reg_w},   {31'd0, m_w});
    chk("model rd_addr",   {27'd0, Rd_addr}, {27'd0, m_addr});
    chk("model rd_data",   Rd_data,          m_data);
    chk("model pending",   pending,          pv);
    chk("model mdu_ready", {31'd0, mdu_ready}, exp_rdy);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
    flush     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    chk("reset reg_w",     {31'd0, Reg_w},     32'd0);
    chk("reset rd_addr",   {27'd0, Rd_addr},   32'd0);
    chk("reset rd_data",   Rd_data,            32'd0);
    chk("reset pending",   pending,            32'd0);
    chk("reset mdu_ready", {31'd0, mdu_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready after reset", {31'd0, mdu_ready}, 32'd1);

    // Single ALU write
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    tick();
    idle();
    chk("alu reg_w",   {31'd0, Reg_w},   32'd1);
    chk("alu rd_addr", {27'd0, Rd_addr}, 32'd5);
    chk("alu rd_data", Rd_data,          32'h1234);
    chk("alu pending", pending,          32'd0);
    tick();
    chk("idle reg_w",  {31'd0, Reg_w},   32'd0);
    chk("hold rd_addr", {27'd0, Rd_addr}, 32'd5);

    // Fill the queue while the ALU owns the port, then drain
    alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h2020;
    for (int i = 1; i <= 4; i++) begin
      mdu_valid = 1'b1; mdu_addr = 5'(i); mdu_data = 32'(100 + i);
      tick();
    end
    mdu_valid = 1'b0; mdu_addr = 5'd5;
    #1;
    chk("full ready",   {31'd0, mdu_ready}, 32'd0);
    chk("full pending", pending,            32'h1E);
    alu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain reg_w",   {31'd0, Reg_w},   32'd1);
      chk("drain rd_addr", {27'd0, Rd_addr}, 32'(i));
      chk("drain rd_data", Rd_data,          32'(100 + i));
      if (i == 1) chk("ready after pop", {31'd0, mdu_ready}, 32'd1);
    end
    chk("drained pending", pending, 32'd0);
    tick();

    // ALU overwrite kills a queued result
    alu_valid = 1'b1; alu_addr = 5'd0;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'hAAAA;
    tick();
    chk("kill queued pending", pending, 32'h80);
    mdu_valid = 1'b0; alu_addr = 5'd7; alu_data = 32'hBBBB;
    tick();
    idle();
    chk("kill reg_w",   {31'd0, Reg_w},   32'd1);
    chk("kill rd_addr", {27'd0, Rd_addr}, 32'd7);
    chk("kill rd_data", Rd_data,          32'hBBBB);
    chk("kill pending", pending,          32'd0);
    repeat (2) begin
      tick();
      chk("killed no write", {31'd0, Reg_w}, 32'd0);
    end
    chk("kill keeps data", Rd_data, 32'hBBBB);

    // MDU write to r0
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h5555;
    #1;
    chk("r0 ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    idle();
    chk("r0 reg_w",   {31'd0, Reg_w}, 32'd0);
    chk("r0 pending", pending,        32'd0);
    tick();
    chk("r0 reg_w late", {31'd0, Reg_w}, 32'd0);

    // Flush three queued results; ALU write in the flush cycle survives
    alu_valid = 1'b1; alu_addr = 5'd0;
    for (int i = 10; i <= 12; i++) begin
      mdu_valid = 1'b1; mdu_addr = 5'(i); mdu_data = 32'(i);
      tick();
    end
    mdu_valid = 1'b0;
    chk("pre-flush pending", pending, 32'h1C00);
    flush = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
    #1;
    chk("flush ready", {31'd0, mdu_ready}, 32'd0);
    tick();
    idle();
    #1;
    chk("post-flush ready",   {31'd0, mdu_ready}, 32'd1);
    chk("flush alu reg_w",    {31'd0, Reg_w},     32'd1);
    chk("flush alu rd_addr",  {27'd0, Rd_addr},   32'd3);
    chk("post-flush pending", pending,            32'd0);
    repeat (3) begin
      tick();
      chk("post-flush reg_w", {31'd0, Reg_w}, 32'd0);
    end

    // Latency of a lone MDU result
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h99;
    tick();
    mdu_valid = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
    chk("lat N+1 reg_w",   {31'd0, Reg_w},   32'd1);
    chk("lat N+1 rd_addr", {27'd0, Rd_addr}, 32'd9);
    tick();
    chk("lat N+2 reg_w",   {31'd0, Reg_w},   32'd0);
`else
    chk("lat N+1 reg_w",   {31'd0, Reg_w},   32'd0);
    tick();
    chk("lat N+2 reg_w",   {31'd0, Reg_w},   32'd1);
    chk("lat N+2 rd_addr", {27'd0, Rd_addr}, 32'd9);
    chk("lat N+2 rd_data", Rd_data,          32'h99);
`endif
    tick();

    // Reset in the middle of a drain
    alu_valid = 1'b1; alu_addr = 5'd0;
    for (int i = 13; i <= 15; i++) begin
      mdu_valid = 1'b1; mdu_addr = 5'(i); mdu_data = 32'(i + 1000);
      tick();
    end
    idle();
    tick();
    chk("mid-drain rd_addr", {27'd0, Rd_addr}, 32'd13);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reg_w",     {31'd0, Reg_w},     32'd0);
    chk("async rd_addr",   {27'd0, Rd_addr},   32'd0);
    chk("async rd_data",   Rd_data,            32'd0);
    chk("async pending",   pending,            32'd0);
    chk("async mdu_ready", {31'd0, mdu_ready}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset ready",   {31'd0, mdu_ready}, 32'd1);
    chk("post-reset reg_w",   {31'd0, Reg_w},     32'd0);
    chk("post-reset pending", pending,            32'd0);
    repeat (3) begin
      tick();
      chk("no stale write", {31'd0, Reg_w}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
